calc_seq_engine: RTL and testbench



---
 rtl/calc_seq_engine.sv | 183 ++++++++++++++++++
 tb/tb_calc_seq_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/calc_seq_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_seq_engine : multi-cycle arithmetic engine (iterative MUL/DIV, flags);
// optional accumulator operand via macro CALC_ACCUM_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module calc_seq_engine #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef CALC_ACCUM_EN
  input  logic               use_acc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               div_zero
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] C_OP_ADD = 3'd0;
  localparam logic [2:0] C_OP_SUB = 3'd1;
  localparam logic [2:0] C_OP_MUL = 3'd2;
  localparam logic [2:0] C_OP_DIV = 3'd3;
  localparam logic [2:0] C_OP_AND = 3'd4;
  localparam logic [2:0] C_OP_OR  = 3'd5;
  localparam logic [2:0] C_OP_XOR = 3'd6;
  localparam logic [2:0] C_OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_work;

  logic             w_accept;
  logic             w_multi;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [RW-1:0]    w_res;
  logic             w_carry;
  logic             w_dz;

  logic [WIDTH:0]   w_mul_sum;
  logic [RW-1:0]    w_mul_next;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_trial_sub;
  logic [RW-1:0]    w_div_next;
  logic [RW-1:0]    w_iter_next;

`ifdef CALC_ACCUM_EN
  assign w_opa = use_acc ? result[WIDTH-1:0] : a;
`else
  assign w_opa = a;
`endif

  // Start is only honoured in IDLE; RUN and DONE drop it without queueing.
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_multi  = (op == C_OP_MUL) || ((op == C_OP_DIV) && (b != '0));

  assign w_sum  = {1'b0, w_opa} + {1'b0, b};
  assign w_diff = {1'b0, w_opa} - {1'b0, b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_dz    = 1'b0;
    case (op)
      C_OP_ADD: begin
        w_res[WIDTH:0] = w_sum;
        w_carry        = w_sum[WIDTH];
      end
      C_OP_SUB: begin
        w_res[WIDTH-1:0] = w_diff[WIDTH-1:0];
        w_carry          = w_diff[WIDTH];
      end
      C_OP_DIV: begin
        w_res = '1;
        w_dz  = 1'b1;
      end
      C_OP_AND: w_res[WIDTH-1:0] = w_opa & b;
      C_OP_OR:  w_res[WIDTH-1:0] = w_opa | b;
      C_OP_XOR: w_res[WIDTH-1:0] = w_opa ^ b;
      C_OP_CMP: begin
        if (w_opa == b)     w_res[1:0] = 2'd0;
        else if (w_opa < b) w_res[1:0] = 2'd1;
        else                w_res[1:0] = 2'd2;
      end
      default: w_res = '0;
    endcase
  end

  // Shift-add multiply: upper half accumulates, lower half holds the
  // unconsumed multiplier bits and fills with product bits as it shifts.
  assign w_mul_sum  = {1'b0, r_work[RW-1:WIDTH]} + (r_work[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_work[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half the
  // dividend shifting out while quotient bits shift in.
  assign w_trial     = {r_work[RW-1:WIDTH], r_work[WIDTH-1]};
  assign w_trial_sub = w_trial[WIDTH-1:0] - r_b;
  assign w_div_next  = (w_trial >= {1'b0, r_b})
                       ? {w_trial_sub, r_work[WIDTH-2:0], 1'b1}
                       : {w_trial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};

  assign w_iter_next = (r_op == C_OP_MUL) ? w_mul_next : w_div_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = w_multi ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_work   <= '0;
      result   <= '0;
      carry    <= 1'b0;
      div_zero <= 1'b0;
    end else if (w_accept) begin
      r_op   <= op;
      r_a    <= w_opa;
      r_b    <= b;
      r_cnt  <= CW'(WIDTH - 1);
      r_work <= (op == C_OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, w_opa};
      if (!w_multi) begin
        result   <= w_res;
        carry    <= w_carry;
        div_zero <= w_dz;
      end
    end else if (r_state == S_RUN) begin
      r_work <= w_iter_next;
      r_cnt  <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        result   <= w_iter_next;
        carry    <= 1'b0;
        div_zero <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_calc_seq_engine : directed self-checking bench for calc_seq_engine
// (WIDTH=8; accumulator steps included when CALC_ACCUM_EN is defined). Rev 1.0
// ---------------------------------------------------------------------------
module tb_calc_seq_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        use_acc;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        div_zero;

  int checks;
  int errors;

  calc_seq_engine #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
`ifdef CALC_ACCUM_EN
    .use_acc  (use_acc),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start, scramble the operand inputs afterwards, then measure
  // latency and busy cycles up to the done pulse and check the outputs.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic acc, input int exp_lat,
                       input int exp_busy, input logic [15:0] exp_res,
                       input logic exp_c, input logic exp_dz);
    int n;
    int nb;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; use_acc = acc;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y; use_acc = ~acc;
    n = 1; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s.latency", tag), n, exp_lat);
    chk($sformatf("%s.busy_cycles", tag), nb, exp_busy);
    chk($sformatf("%s.result", tag), {16'h0, result}, {16'h0, exp_res});
    chk($sformatf("%s.carry", tag), {31'h0, carry}, {31'h0, exp_c});
    chk($sformatf("%s.div_zero", tag), {31'h0, div_zero}, {31'h0, exp_dz});
    @(posedge clk); #1;
    chk($sformatf("%s.done_pulse", tag), {31'h0, done}, 32'h0);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; use_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk("rst.result", {16'h0, result}, 32'h0);
    chk("rst.carry", {31'h0, carry}, 32'h0);
    chk("rst.div_zero", {31'h0, div_zero}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    do_op("add200_100", 3'd0, 8'd200, 8'd100, 1'b0, 1, 0, 16'h012C, 1'b1, 1'b0);
    do_op("add0_0",     3'd0, 8'd0,   8'd0,   1'b0, 1, 0, 16'h0000, 1'b0, 1'b0);
    do_op("mul255_255", 3'd2, 8'd255, 8'd255, 1'b0, 9, 8, 16'hFE01, 1'b0, 1'b0);
    do_op("div200_7",   3'd3, 8'd200, 8'd7,   1'b0, 9, 8, 16'h041C, 1'b0, 1'b0);
    do_op("div9_0",     3'd3, 8'd9,   8'd0,   1'b0, 1, 0, 16'hFFFF, 1'b0, 1'b1);
    do_op("div255_1",   3'd3, 8'd255, 8'd1,   1'b0, 9, 8, 16'h00FF, 1'b0, 1'b0);
    do_op("div13_200",  3'd3, 8'd13,  8'd200, 1'b0, 9, 8, 16'h0D00, 1'b0, 1'b0);

    // MUL 3*5 with an ADD start pulsed during RUN and an XOR start in DONE.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 8'd3; b = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; a = 8'd0; b = 8'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mul3_5.latency", n, 9);
    chk("mul3_5.result", {16'h0, result}, 32'h0000_000F);
    start = 1'b1; op = 3'd6; a = 8'hF0; b = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mul3_5.start_in_done.done", {31'h0, done}, 32'h0);
    chk("mul3_5.start_in_done.result", {16'h0, result}, 32'h0000_000F);
    do_op("add1_1_after", 3'd0, 8'd1, 8'd1, 1'b0, 1, 0, 16'h0002, 1'b0, 1'b0);

    // Reset asserted during the fourth RUN cycle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 8'd200; b = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("midrst.busy", {31'h0, busy}, 32'h0);
    chk("midrst.result", {16'h0, result}, 32'h0);
    chk("midrst.done", {31'h0, done}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("midrst.no_done", n, 0);

    do_op("sub5_9",   3'd1, 8'd5,   8'd9,   1'b0, 1, 0, 16'h00FC, 1'b1, 1'b0);
    do_op("cmp7_7",   3'd7, 8'd7,   8'd7,   1'b0, 1, 0, 16'h0000, 1'b0, 1'b0);
    do_op("sub9_5",   3'd1, 8'd9,   8'd5,   1'b0, 1, 0, 16'h0004, 1'b0, 1'b0);
    do_op("cmp3_9",   3'd7, 8'd3,   8'd9,   1'b0, 1, 0, 16'h0001, 1'b0, 1'b0);
    do_op("cmp9_3",   3'd7, 8'd9,   8'd3,   1'b0, 1, 0, 16'h0002, 1'b0, 1'b0);
    do_op("and",      3'd4, 8'hF0,  8'h3C,  1'b0, 1, 0, 16'h0030, 1'b0, 1'b0);
    do_op("or",       3'd5, 8'hA0,  8'h05,  1'b0, 1, 0, 16'h00A5, 1'b0, 1'b0);
    do_op("xor",      3'd6, 8'hFF,  8'h0F,  1'b0, 1, 0, 16'h00F0, 1'b0, 1'b0);
    do_op("div0_flag", 3'd3, 8'd1,  8'd0,   1'b0, 1, 0, 16'hFFFF, 1'b0, 1'b1);
    do_op("mul12_11", 3'd2, 8'd12,  8'd11,  1'b0, 9, 8, 16'h0084, 1'b0, 1'b0);

`ifdef CALC_ACCUM_EN
    do_op("acc.add10_20", 3'd0, 8'd10, 8'd20, 1'b0, 1, 0, 16'h001E, 1'b0, 1'b0);
    do_op("acc.add_acc5", 3'd0, 8'd99, 8'd5,  1'b1, 1, 0, 16'h0023, 1'b0, 1'b0);
    do_op("acc.mul_acc3", 3'd2, 8'd1,  8'd3,  1'b1, 9, 8, 16'h0069, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
